// File: rtl/deserializer_top.sv
// Serial-to-parallel byte receiver feeding an 8-entry byte FIFO.
// Bits are sampled on a divided tick and assembled MSB-first.
module deserializer_top #(
   parameter int DIV   = 10,
   parameter int DEPTH = 8
) (
   input  logic       clock_1M,
   input  logic       reset,
   input  logic       data_in,
   input  logic       write_in,
   input  logic       deq_in,
   output logic [7:0] data_out,
   output logic [3:0] len_out,
   output logic       status_out
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);

   logic [CW-1:0] div_cnt;
   logic          tick;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          pend;
   logic          hold;
   logic          deq_q;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [NW-1:0] count;
   logic [7:0]    mem [DEPTH];

   logic accept;
   logic pop;
   logic push;
   logic full;

   assign tick   = (div_cnt == CW'(DIV - 1));
   assign accept = tick & write_in & ~pend;
   assign full   = (count == NW'(DEPTH));
   assign pop    = deq_in & ~deq_q & (count != '0);
   // a pop in the same cycle frees a slot for a waiting byte
   assign push   = pend & (~full | pop);

   // free-running sample divider, restarts from 0 after reset
   always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   // shift in sampled bits; flag a complete byte for the FIFO
   always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
         shift   <= '0;
         bit_cnt <= '0;
         pend    <= 1'b0;
         hold    <= 1'b0;
      end else begin
         if (push) begin
            pend <= 1'b0;
            hold <= 1'b0;
         end else if (pend) begin
            hold <= 1'b1;
         end
         if (accept) begin
            shift   <= {shift[6:0], data_in};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               pend <= 1'b1;
            end
         end
      end
   end

   // dequeue edge detect, pointers and occupancy
   always_ff @(posedge clock_1M or negedge reset) begin
      if (!reset) begin
         deq_q  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         deq_q <= deq_in;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage array needs no reset; count gates visibility
   always_ff @(posedge clock_1M) begin
      if (push) begin
         mem[wr_ptr] <= shift;
      end
   end

   assign data_out   = (count != '0) ? mem[rd_ptr] : 8'h00;
   assign len_out    = 4'(count);
   assign status_out = ~hold;

endmodule

// File: tb/tb_deserializer_top.sv
// Directed and randomized bench for deserializer_top with
// a queue-based reference model of the byte stream.
`timescale 1ns/1ps
module tb_deserializer_top;

   logic       clk;
   logic       reset;
   logic       data_in;
   logic       write_in;
   logic       deq_in;
   logic [7:0] data_out;
   logic [3:0] len_out;
   logic       status_out;

   int checks = 0;
   int passes = 0;

   byte unsigned q[$];
   bit   [7:0]   acc;
   int           nb;
   bit           mheld;
   bit   [7:0]   hbyte;

   deserializer_top #(.DIV(10), .DEPTH(8)) dut (
      .clock_1M  (clk),
      .reset     (reset),
      .data_in   (data_in),
      .write_in  (write_in),
      .deq_in    (deq_in),
      .data_out  (data_out),
      .len_out   (len_out),
      .status_out(status_out)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   task automatic mreset();
      q.delete();
      acc   = '0;
      nb    = 0;
      mheld = 1'b0;
      hbyte = '0;
   endtask

   task automatic mbit(input bit b);
      if (!mheld) begin
         acc = {acc[6:0], b};
         nb++;
         if (nb == 8) begin
            nb = 0;
            if (q.size() < 8) q.push_back(acc);
            else begin
               mheld = 1'b1;
               hbyte = acc;
            end
         end
      end
   endtask

   task automatic mpop();
      if (q.size() > 0) begin
         void'(q.pop_front());
         if (mheld) begin
            q.push_back(hbyte);
            mheld = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_outs(input string tag);
      int ed;
      ed = (q.size() > 0) ? int'(q[0]) : 0;
      chk({tag, ".data"}, int'(data_out), ed);
      chk({tag, ".len"}, int'(len_out), q.size());
      chk({tag, ".status"}, int'(status_out), int'(!mheld));
   endtask

   task automatic send_bit(input bit b, input bit gap);
      data_in  = b;
      write_in = 1'b1;
      repeat (10) @(negedge clk);
      mbit(b);
      if (gap) begin
         write_in = 1'b0;
         data_in  = 1'($urandom);
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic send_byte(input bit [7:0] v, input bit gap);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
      write_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic deq_pulse(input int w);
      deq_in = 1'b1;
      repeat (w) @(negedge clk);
      deq_in = 1'b0;
      mpop();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      data_in  = 1'b0;
      write_in = 1'b0;
      deq_in   = 1'b0;
      mreset();
      repeat (5) @(negedge clk);
      check_outs("rst_held");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_outs("rst_rel");
      deq_pulse(1);
      check_outs("deq_empty");

      send_byte(8'hAA, 1'b0);
      check_outs("byte_aa");
      chk("aa_value", int'(data_out), 8'hAA);
      send_byte(8'h55, 1'b1);
      check_outs("byte_55");
      send_byte(8'hCC, 1'b1);
      check_outs("byte_cc");
      deq_pulse(15);
      check_outs("pop_wide");
      chk("pop_wide_55", int'(data_out), 8'h55);
      deq_pulse(3);
      check_outs("pop_cc");
      deq_pulse(1);
      check_outs("pop_empty");

      for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
      check_outs("full8");
      send_byte(8'hF0, 1'b0);
      check_outs("held_f0");
      chk("held_status", int'(status_out), 0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      write_in = 1'b0;
      repeat (2) @(negedge clk);
      check_outs("ignored");
      deq_pulse(2);
      check_outs("held_push");
      chk("held_len8", int'(len_out), 8);
      for (int i = 0; i < 7; i++) deq_pulse(1);
      check_outs("wrap_f0");
      chk("wrap_f0_val", int'(data_out), 8'hF0);
      deq_pulse(1);

      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      #100 reset = 1'b0;
      #100 mreset();
      check_outs("async_rst");
      repeat (3) @(negedge clk);
      write_in = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      send_byte(8'h3C, 1'b0);
      check_outs("after_rst");
      chk("after_rst_3c", int'(data_out), 8'h3C);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) < 6) begin
            send_byte(8'($urandom), 1'($urandom));
            check_outs("rnd_send");
         end else begin
            deq_pulse(int'($urandom_range(1, 4)));
            check_outs("rnd_deq");
         end
         if ($urandom_range(0, 3) == 0) begin
            data_in = 1'($urandom);
            repeat (int'($urandom_range(1, 25))) @(negedge clk);
            check_outs("rnd_idle");
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/deserializer_top.md
Name:
deserializer_top

Overview:
- Serial-to-parallel receiver with an output byte FIFO, top level of the deserializer subsystem.
- Bits on data_in, qualified by write_in, are sampled at a divided rate and assembled MSB-first into bytes.
- Each completed byte is pushed into an 8-entry FIFO.
- The consumer reads the FIFO head on data_out, its occupancy on len_out, and pops with a deq_in pulse.

Parameters:
- DIV, 10, clock_1M cycles per bit-sample tick (100 kHz sample rate from 1 MHz).
- DEPTH, 8, FIFO entries; len_out must hold 0..DEPTH.

Ports:
- clock_1M  input  1  single system clock, 1 MHz; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state when 0.
- data_in  input  1  serial data bit, valid while write_in=1.
- write_in  input  1  bit-valid qualifier, sampled on sample ticks only.
- deq_in  input  1  dequeue request; one pop per rising edge (0->1) of deq_in.
- data_out  output  8  FIFO head byte; 8'h00 when FIFO empty.
- len_out  output  4  number of bytes in FIFO, 0..8.
- status_out  output  1  1 = deserializer accepting bits; 0 = completed byte held, FIFO full.

Behaviour:
- Reset (reset=0, asynchronous):
  - divider counter=0, bit counter=0, shift register=0, FIFO pointers and count=0.
  - deq_in edge-detect register=0, hold flag=0.
  - data_out=8'h00, len_out=0, status_out=1.
- Sample tick:
  - Divider counts 0..DIV-1 on clock_1M and wraps.
  - tick=1 for one clock when counter==DIV-1.
  - Counting starts from 0 after reset release.
  - A bit held with write_in=1 for exactly DIV clocks is therefore sampled exactly once at any phase.
- Deserializer:
  - On a tick with write_in=1 and status_out=1: shift={shift[6:0],data_in}, bit counter++. First bit received ends up in bit 7.
  - When the 8th bit is captured: bit counter returns to 0 and the byte is pushed on the next clock_1M edge.
  - If the FIFO is full at push time: the byte is held, hold flag=1, status_out=0, and ticks with write_in=1 are ignored (bits lost).
  - The held byte is pushed on the first clock edge where the FIFO is not full; then hold flag=0 and status_out=1.
  - Ticks with write_in=0 change nothing; a partial byte is retained indefinitely.
- FIFO:
  - Circular buffer of DEPTH entries with 3-bit read/write pointers that wrap 7->0.
  - Push writes at the write pointer then increments it; pop increments the read pointer.
  - len_out = count.
  - data_out is combinational from the head entry when count>0, else 8'h00.
- Dequeue:
  - deq_in is registered each clock; pop request = deq_in & ~deq_q, giving one pop per pulse regardless of width.
  - Pop when empty is ignored; len stays 0.
- Simultaneous push and pop in one clock:
  - Both are performed and count is unchanged.
  - When full, the pop frees space so the held push proceeds that cycle.
  - When empty, the push proceeds and the pop is ignored.
- Reset mid-byte or mid-operation discards the partial byte and all FIFO contents immediately.

Test Plan:
1. Reset held 5 us then released -> data_out=00, len_out=0, status_out=1. deq_in pulse while empty -> len_out stays 0.
2. write_in=1 continuously, bits 1,0,1,0,1,0,1,0 each held 10 us -> len_out=1, data_out=AA within one clock after the 8th sample.
3. Bits 0,1,0,1,0,1,0,1 each sent as write_in=1 for 10 us then write_in=0 for 10 us -> len_out=2, data_out remains AA (FIFO order).
4. Then byte 11001100 sent the same way -> len_out=3. deq_in high 15 us -> exactly one pop: len_out=2, data_out=55. Second pulse -> len_out=1, data_out=CC.
5. Push 8 bytes (00..07), then send a 9th byte F0 -> len_out=8, status_out=0, data_out=00. Further bits ignored. One deq pulse -> len_out=8 (held F0 pushed), status_out=1, data_out=01. After 7 more pops, data_out=F0 (pointer wrap verified).
6. Assert reset after 4 bits of a byte with len_out=2 -> outputs return to 00/0/1. A fresh full byte 3C then gives len_out=1, data_out=3C (partial bits discarded).
